addr_gen_2d: RTL and testbench
==============================

// Module: addr_gen_2d
//
// PURPOSE
// - Parametrised 2-D raster address generator for the AHB master's image
//   read and write-back paths.
// - Walks a rectangular pixel region of a frame buffer one beat per accepted
//   step, with a programmable row pitch and an optional symmetric border
//   skip. Border skip serves the 3x3 edge-detect output, which is smaller
//   than the input frame.
// - Replaces the fixed +4 write-side address updater.
// - Reports row end and frame end, and supports abort.
//
// PARAMETERS
// ADDR_W          32   width of bus addresses and row pitch
// DIM_W           16   width of the image width/length fields (in beats)
// BYTES_PER_BEAT  4    address increment per step; power of two
//
// PORTS
// HCLK         in   1       system clock; all state changes on rising edge
// HRESETn      in   1       asynchronous active-low reset
// start        in   1       latch config and begin a frame (honoured only in IDLE)
// abort        in   1       abandon the current frame
// base_addr    in   ADDR_W  byte address of pixel (0,0)
// img_width    in   DIM_W   beats per row, before border skip
// img_length   in   DIM_W   rows, before border skip
// row_pitch    in   ADDR_W  byte distance between consecutive row starts
// border       in   2       rows/cols skipped at each edge (0..3)
// step         in   1       current address consumed; advance
// curr_addr    out  ADDR_W  address of the current beat
// addr_valid   out  1       curr_addr is valid
// last_in_row  out  1       curr_addr is the final beat of its row
// busy         out  1       frame in progress (RUN state)
// done         out  1       one-cycle pulse at frame completion
//
// BEHAVIOUR
// - Reset: all outputs, counters and latched config clear to 0. State = IDLE.
//   Reset asserted mid-frame discards the frame and produces no done pulse.
// - FSM states and transitions:
//   - IDLE: on start, go to RUN, or to DONE if the frame is degenerate.
//   - RUN: on step at the final beat, go to DONE; on abort, go to IDLE.
//   - DONE: always go to IDLE after one cycle.
// - Start:
//   - On start, latch all config inputs. Config changes during a frame are
//     ignored.
//   - Effective size: W' = img_width - 2*border, L' = img_length - 2*border.
//   - If img_width <= 2*border or img_length <= 2*border, go to DONE: no
//     addresses are emitted, and done pulses in the cycle after start.
//   - Otherwise, the first address is
//     base + border*row_pitch + border*BYTES_PER_BEAT.
//   - That first address is registered and visible with addr_valid=1 in the
//     cycle after start.
// - RUN stepping, with col/row counters starting at 0:
//   - step=0: curr_addr and the counters hold.
//   - step=1 with col < W'-1: col+1, curr_addr += BYTES_PER_BEAT.
//   - step=1 with col == W'-1 and row < L'-1: col=0, row+1, and
//     row_start += row_pitch; curr_addr = new row_start.
//   - step=1 with col == W'-1 and row == L'-1: go to DONE, addr_valid=0.
// - Output flags:
//   - last_in_row = addr_valid && col == W'-1 (combinational from registers).
//   - busy = 1 only in RUN; done = 1 only in DONE.
// - Arithmetic:
//   - All address arithmetic is modulo 2^ADDR_W; wrap-around is silent.
//   - border*row_pitch uses shift-add; no multiplier.
// - Ignored and priority cases:
//   - step is ignored outside RUN.
//   - start is ignored outside IDLE.
//   - abort wins over a simultaneous step: no advance, IDLE next cycle,
//     addr_valid=0, no done pulse.
//   - abort in IDLE or DONE has no effect.
//
// STRUCTURE
// - Package addr_gen_pkg holds the state enum (IDLE, RUN, DONE) and the
//   MAX_BORDER=3 constant.
// - One sub-module, dim_counter: a DIM_W-bit counter with clear, inc and a
//   terminal flag against a limit. It is instantiated twice, for col and row.
// - Address/row_start registers and the FSM live in the top module.
//
// TESTING
// 1. base=0x1000, W=4, L=3, pitch=0x10, border=0, step held 1 -> 12 addrs:
//    0x1000..0x100C, 0x1010..0x101C, 0x1020..0x102C. last_in_row on 0x100C,
//    0x101C and 0x102C. done pulses one cycle after the step on 0x102C.
// 2. base=0, W=5, L=4, pitch=0x14, border=1 -> 0x18, 0x1C, 0x20, 0x2C, 0x30,
//    0x34, then done.
// 3. W=2, L=8, border=1 -> addr_valid never rises; done=1 exactly in the
//    cycle after start; busy stays 0.
// 4. Case 1 with step toggled 1,0,1,0 -> curr_addr holds on step=0 cycles.
//    Same 12-address sequence, done after the 12th accepted step.
//    start pulsed mid-frame has no effect.
// 5. abort with step=1 during row 1 -> IDLE next cycle, addr_valid=0, no
//    done. New start restarts at base. Repeat with HRESETn dropped mid-row
//    -> outputs 0 immediately.
// 6. base=0xFFFF_FFF8, W=4, L=1, border=0 -> 0xFFFF_FFF8, 0xFFFF_FFFC,
//    0x0000_0000, 0x0000_0004, then done.

Source files
------------

// File: rtl/addr_gen_2d_pkg.sv
// addr_gen_pkg: shared state encoding and border limits for the 2-D address generator
package addr_gen_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam int MAX_BORDER = 3;
  localparam int BORDER_W = $clog2(MAX_BORDER + 1);
endpackage

// File: rtl/addr_gen_2d_dim.sv
// dim_counter: clearable up-counter with a terminal flag against a limit
module dim_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  input  logic [DIM_W-1:0] limit_i,
  output logic             term_o
);
  logic [DIM_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr_i ? '0 : inc_i ? cnt_q + DIM_W'(1) : cnt_q;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  assign term_o = cnt_q == limit_i;
endmodule

// File: rtl/addr_gen_2d.sv
// addr_gen_2d: raster address walker over a framed region with row pitch and border skip
module addr_gen_2d
  import addr_gen_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DIM_W          = 16,
  parameter int BYTES_PER_BEAT = 4
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic                start,
  input  logic                abort,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [DIM_W-1:0]    img_width,
  input  logic [DIM_W-1:0]    img_length,
  input  logic [ADDR_W-1:0]   row_pitch,
  input  logic [BORDER_W-1:0] border,
  input  logic                step,
  output logic [ADDR_W-1:0]   curr_addr,
  output logic                addr_valid,
  output logic                last_in_row,
  output logic                busy,
  output logic                done
);
  localparam int SH = $clog2(BYTES_PER_BEAT);
  state_e state_q;
  logic [ADDR_W-1:0] addr_q, row_start_q, pitch_q, b_pitch, first;
  logic [DIM_W-1:0] col_lim_q, row_lim_q, two_b;
  logic valid_q, degen, launch, adv, col_term, row_term;
  assign two_b   = DIM_W'({border, 1'b0});
  assign degen   = img_width <= two_b || img_length <= two_b;
  // border is at most 3, so border*pitch is two conditional shifted adds
  assign b_pitch = (border[0] ? row_pitch : '0) + (border[1] ? row_pitch << 1 : '0);
  assign first   = base_addr + b_pitch + (ADDR_W'(border) << SH);
  assign launch  = state_q == IDLE && start;
  assign adv     = state_q == RUN && step && !abort;
  dim_counter #(.DIM_W(DIM_W)) u_col (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(launch || (adv && col_term)),
    .inc_i(adv), .limit_i(col_lim_q), .term_o(col_term)
  );
  dim_counter #(.DIM_W(DIM_W)) u_row (
    .clk_i(HCLK), .rst_ni(HRESETn), .clr_i(launch),
    .inc_i(adv && col_term), .limit_i(row_lim_q), .term_o(row_term)
  );
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      row_start_q <= '0;
      pitch_q     <= '0;
      col_lim_q   <= '0;
      row_lim_q   <= '0;
      valid_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          pitch_q     <= row_pitch;
          col_lim_q   <= img_width - two_b - DIM_W'(1);
          row_lim_q   <= img_length - two_b - DIM_W'(1);
          addr_q      <= first;
          row_start_q <= first;
          valid_q     <= !degen;
          state_q     <= degen ? DONE : RUN;
        end
        RUN: if (abort) begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end else if (step) begin
          if (col_term && row_term) begin
            state_q <= DONE;
            valid_q <= 1'b0;
          end else if (col_term) begin
            row_start_q <= row_start_q + pitch_q;
            addr_q      <= row_start_q + pitch_q;
          end else addr_q <= addr_q + ADDR_W'(BYTES_PER_BEAT);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign curr_addr   = addr_q;
  assign addr_valid  = valid_q;
  assign last_in_row = valid_q && col_term;
  assign busy        = state_q == RUN;
  assign done        = state_q == DONE;
endmodule

// File: tb/tb_addr_gen_2d.sv
// tb_addr_gen_2d: directed and random frames checked against an address-list model
module tb_addr_gen_2d;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, step = 0;
  logic [31:0] base = 0, pitch = 0, curr_addr;
  logic [15:0] width = 0, length = 0;
  logic [1:0] border = 0;
  logic addr_valid, last_in_row, busy, done;
  int n_cmp = 0, n_bad = 0;

  addr_gen_2d dut (
    .HCLK(clk), .HRESETn(rst_n), .start(start), .abort(abort),
    .base_addr(base), .img_width(width), .img_length(length),
    .row_pitch(pitch), .border(border), .step(step),
    .curr_addr(curr_addr), .addr_valid(addr_valid),
    .last_in_row(last_in_row), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_valid"}, 32'(addr_valid), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_done"}, 32'(done), 0);
  endtask

  // mode 0: step always 1, 1: alternate 1/0, 2: random
  task automatic frame(input logic [31:0] b, input int w, input int l, input logic [31:0] p,
                       input int bd, input int mode, input int abort_at);
    logic [31:0] q[$];
    int wn, k, cyc;
    bit s, ab;
    wn = w - 2 * bd;
    if (w > 2 * bd && l > 2 * bd)
      for (int r = bd; r < l - bd; r++)
        for (int c = bd; c < w - bd; c++)
          q.push_back(b + p * 32'(r) + 32'(c) * 32'd4);
    @(posedge clk) #1;
    base = b; width = 16'(w); length = 16'(l); pitch = p; border = 2'(bd);
    start = 1; step = 1'($urandom);
    @(posedge clk) #1;
    start = 0;
    base = $urandom; width = 16'($urandom); length = 16'($urandom);
    pitch = $urandom; border = 2'($urandom);
    if (q.size() == 0) begin
      step = 0;
      @(negedge clk);
      check("degen_done", 32'(done), 1);
      check("degen_valid", 32'(addr_valid), 0);
      check("degen_busy", 32'(busy), 0);
      @(negedge clk);
      idle_checks("degen_after");
      return;
    end
    k = 0; cyc = 0;
    while (k < q.size()) begin
      s = mode == 0 ? 1'b1 : mode == 1 ? cyc % 2 == 0 : 1'($urandom);
      ab = k == abort_at;
      step = s; abort = ab;
      start = mode != 0 && $urandom_range(0, 2) == 0;
      @(negedge clk);
      check("valid", 32'(addr_valid), 1);
      check("addr", curr_addr, q[k]);
      check("last", 32'(last_in_row), 32'((k % wn) == wn - 1));
      check("busy", 32'(busy), 1);
      check("done", 32'(done), 0);
      @(posedge clk) #1;
      if (ab) begin
        abort = 0; step = 0; start = 0;
        @(negedge clk);
        idle_checks("abort");
        check("abort_addr_hold", curr_addr, q[k]);
        @(negedge clk);
        idle_checks("abort_after");
        return;
      end
      if (s) k++;
      cyc++;
      if (cyc > 2000) begin
        check("frame_timeout", 32'(k), 32'(q.size()));
        $fatal(1, "FAIL frame_timeout stuck at beat %0d", k);
      end
    end
    step = 0; start = 0;
    @(negedge clk);
    check("end_done", 32'(done), 1);
    check("end_valid", 32'(addr_valid), 0);
    check("end_busy", 32'(busy), 0);
    @(negedge clk);
    idle_checks("end_after");
  endtask

  initial begin
    #12;
    check("rst_addr", curr_addr, 0);
    idle_checks("rst");
    check("rst_last", 32'(last_in_row), 0);
    @(posedge clk) #1 rst_n = 1;
    frame(32'h1000, 4, 3, 32'h10, 0, 0, -1);
    frame(32'h0, 5, 4, 32'h14, 1, 0, -1);
    frame(32'h2000, 2, 8, 32'h40, 1, 0, -1);
    frame(32'h1000, 4, 3, 32'h10, 0, 1, -1);
    frame(32'h1000, 4, 3, 32'h10, 0, 0, 5);
    frame(32'h1000, 4, 3, 32'h10, 0, 0, -1);
    frame(32'hFFFF_FFF8, 4, 1, 32'h10, 0, 0, -1);
    frame(32'h3000, 9, 7, 32'h100, 3, 2, -1);
    // abort in IDLE must be a no-op
    @(posedge clk) #1 abort = 1; step = 1;
    @(negedge clk) idle_checks("idle_abort");
    @(posedge clk) #1 abort = 0; step = 0;
    // reset dropped mid-row clears outputs immediately and suppresses done
    @(posedge clk) #1;
    base = 32'h1000; width = 4; length = 3; pitch = 32'h10; border = 0; start = 1;
    @(posedge clk) #1 start = 0; step = 1;
    repeat (5) @(posedge clk);
    #2 rst_n = 0;
    #1;
    check("arst_addr", curr_addr, 0);
    check("arst_last", 32'(last_in_row), 0);
    idle_checks("arst");
    @(posedge clk) #3 rst_n = 1;
    repeat (3) begin
      @(negedge clk);
      idle_checks("arst_after");
    end
    step = 0;
    frame(32'h1000, 4, 3, 32'h10, 0, 0, -1);
    for (int i = 0; i < 30; i++)
      frame($urandom, $urandom_range(1, 9), $urandom_range(1, 6), $urandom,
            $urandom_range(0, 3), 2, $urandom_range(0, 3) == 0 ? $urandom_range(0, 20) : -1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
